// File: rtl/inst_d.sv
// inst_d: decode stage holding the IF/ID register, the register file and the registered ID/EX bundle.
// Define RF_BYPASS_EN to let register reads see a same-cycle writeback (write-through).
module inst_d #(
  parameter int          DATA_W   = 32,
  parameter int          REG_N    = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [31:0]       pc_in,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_data,
  output logic [4:0]        rs_f_id,
  output logic [4:0]        rt_f_id,
  output logic [4:0]        rd_f_id,
  output logic [4:0]        id_dest,
  output logic              ex_valid,
  output logic [5:0]        ex_op,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_dest,
  output logic [31:0]       ex_pc,
  output logic              ex_reg_write,
  output logic              ex_use_imm,
  output logic              ex_is_load,
  output logic              ex_is_store,
  output logic              ex_is_branch,
  output logic              halted,
  output logic              illegal_op
);
  localparam logic [5:0] OP_ALU_END = 6'd12;
  localparam logic [5:0] OP_LDW     = 6'd12;
  localparam logic [5:0] OP_STW     = 6'd13;
  localparam logic [5:0] OP_BZ      = 6'd14;
  localparam logic [5:0] OP_BEQ     = 6'd15;
  localparam logic [5:0] OP_JR      = 6'd16;
  localparam logic [5:0] OP_HALT    = 6'd17;

  typedef struct packed {
    logic              valid;
    logic [5:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [31:0]       imm;
    logic [4:0]        dest;
    logic [31:0]       pc;
    logic              reg_write;
    logic              use_imm;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
  } ex_t;

  logic [31:0]       word_q, word_d, pc_q, pc_d;
  logic [DATA_W-1:0] rf_q [REG_N];
  ex_t               ex_q, ex_d;
  logic              halted_q, halted_d, illegal_q, illegal_d;
  logic [5:0]        op;
  logic [4:0]        rs, rt, rd, dest;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic              is_r, is_i, is_ld, is_st, is_br, is_halt, legal, bubble;

  assign op = word_q[31:26];
  assign rs = word_q[25:21];
  assign rt = word_q[20:16];
  assign rd = word_q[15:11];

  // ALU opcodes sit below LDW: even codes are register-register, odd codes take the immediate
  assign is_r    = (op < OP_ALU_END) && !op[0];
  assign is_i    = (op < OP_ALU_END) && op[0];
  assign is_ld   = op == OP_LDW;
  assign is_st   = op == OP_STW;
  assign is_br   = (op == OP_BZ) || (op == OP_BEQ) || (op == OP_JR);
  assign is_halt = op == OP_HALT;
  assign legal   = op <= OP_HALT;
  assign dest    = is_r ? rd : (is_i || is_ld) ? rt : 5'd0;

`ifdef RF_BYPASS_EN
  assign rs_val = (rs == 5'd0) ? '0 : (wb_en && wb_dest == rs) ? wb_data : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : (wb_en && wb_dest == rt) ? wb_data : rf_q[rt];
`else
  assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];
`endif

  assign word_d = flush ? NOP_WORD : stall ? word_q : instruction;
  assign pc_d   = flush ? 32'd0 : stall ? pc_q : pc_in;

  // Once halted, nothing further may reach execute
  assign bubble    = stall || (word_q == NOP_WORD) || halted_q;
  assign illegal_d = !bubble && !legal;
  assign halted_d  = halted_q || (!bubble && is_halt);

  always_comb begin
    ex_d = '0;
    if (!bubble && legal) begin
      ex_d.valid     = 1'b1;
      ex_d.op        = op;
      ex_d.rs_val    = rs_val;
      ex_d.rt_val    = rt_val;
      ex_d.imm       = {{16{word_q[15]}}, word_q[15:0]};
      ex_d.dest      = dest;
      ex_d.pc        = pc_q;
      ex_d.reg_write = dest != 5'd0;
      ex_d.use_imm   = is_i || is_ld || is_st;
      ex_d.is_load   = is_ld;
      ex_d.is_store  = is_st;
      ex_d.is_branch = is_br;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      word_q    <= NOP_WORD;
      pc_q      <= '0;
      ex_q      <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      word_q    <= word_d;
      pc_q      <= pc_d;
      ex_q      <= ex_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) rf_q <= '{default: '0};
    else if (wb_en && wb_dest != 5'd0) rf_q[wb_dest] <= wb_data;

  assign rs_f_id      = rs;
  assign rt_f_id      = rt;
  assign rd_f_id      = rd;
  assign id_dest      = ex_q.dest;
  assign ex_dest      = ex_q.dest;
  assign ex_valid     = ex_q.valid;
  assign ex_op        = ex_q.op;
  assign ex_rs_val    = ex_q.rs_val;
  assign ex_rt_val    = ex_q.rt_val;
  assign ex_imm       = ex_q.imm;
  assign ex_pc        = ex_q.pc;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_use_imm   = ex_q.use_imm;
  assign ex_is_load   = ex_q.is_load;
  assign ex_is_store  = ex_q.is_store;
  assign ex_is_branch = ex_q.is_branch;
  assign halted       = halted_q;
  assign illegal_op   = illegal_q;
endmodule

// File: doc/inst_d.md
Name: inst_d

Overview:
Instruction decode stage, directly downstream of instruction fetch (inst_f). It holds the IF/ID pipeline register and the 32-entry architectural register file. It decodes the 6-bit opcode and fields, sign-extends the immediate, and drives a registered ID/EX bundle to execute. It also returns the decoded source fields and ID-stage destination to fetch for hazard detection.

Parameters:
DATA_W, 32, register and operand width
REG_N, 32, number of registers; r0 hardwired to zero
NOP_WORD, 32'h0000_0000, instruction word inserted on flush/bubble (ADD r0,r0,r0)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
instruction  in  32  fetched word from inst_f
pc_in  in  32  PC of the fetched word (inst_f pc_out)
stall  in  1  hold IF/ID; inject a bubble into ID/EX
flush  in  1  replace IF/ID contents with NOP_WORD (taken branch/jump)
wb_en  in  1  register-file write enable from writeback
wb_dest  in  5  writeback register index
wb_data  in  DATA_W  writeback data
rs_f_id / rt_f_id / rd_f_id  out  5 each  raw fields [25:21]/[20:16]/[15:11] of the IF/ID word, combinational
id_dest  out  5  destination of the ID/EX instruction; 0 if no register write or bubble
ex_valid  out  1  ID/EX holds a real instruction
ex_op  out  6  opcode
ex_rs_val / ex_rt_val  out  DATA_W each  register operands
ex_imm  out  32  sign-extended imm[15:0]
ex_dest  out  5  same value as id_dest
ex_pc  out  32  PC of the ID/EX instruction
ex_reg_write, ex_use_imm, ex_is_load, ex_is_store, ex_is_branch  out  1 each  control bits
halted  out  1  sticky; HALT has reached ID/EX
illegal_op  out  1  one-cycle pulse; undefined opcode decoded

Behaviour:
- Opcodes:
  - R-type ALU (dest rd): ADD 000000, SUB 000010, MUL 000100, OR 000110, AND 001000, XOR 001010.
  - I-type ALU (dest rt, use_imm=1): ADDI 000001, SUBI 000011, MULI 000101, ORI 000111, ANDI 001001, XORI 001011.
  - LDW 001100: dest rt, is_load, use_imm.
  - STW 001101: no dest, is_store, use_imm.
  - BZ 001110, BEQ 001111, JR 010000: no dest, is_branch.
  - HALT 010001.
  - Any other opcode: decoded as NOP, illegal_op=1 for that cycle.
- reg_write = 1 only for dest-writing opcodes with dest != 0.
- id_dest = 0 whenever reg_write = 0.
- Reset (rst=0):
  - IF/ID word = NOP_WORD, IF/ID PC = 0.
  - All registers = 0.
  - All ex_* outputs, id_dest, halted and illegal_op = 0.
- IF/ID update at each posedge:
  - flush=1: load NOP_WORD (flush has priority over stall).
  - else stall=1: hold.
  - else: capture instruction/pc_in.
- ID/EX update at each posedge:
  - stall=1 or IF/ID word is NOP_WORD: bubble (ex_valid=0, all control bits and ex_dest = 0).
  - else: register the decoded fields.
- Latency: word presented before edge N is captured at edge N and appears on ex_* after edge N+1.
- Register file:
  - Writes on posedge when wb_en=1 and wb_dest != 0; writes to r0 are ignored.
  - Reads are combinational from IF/ID rs/rt.
- halted:
  - Set at the edge HALT enters ID/EX.
  - Once set, every later ID/EX load is a bubble.
  - Cleared only by reset.
- A reset asserted mid-operation clears everything immediately (asynchronous), including halted.
- Simultaneous stall+flush: IF/ID takes NOP_WORD and ID/EX takes a bubble.

Optional Feature:
RF_BYPASS_EN
- Defined: a read whose index equals wb_dest while wb_en=1 (and index != 0) returns wb_data in the same cycle (write-through).
- Undefined: the read returns the pre-write value; the new value is visible the cycle after the write.

Test Plan:
- Reset, then feed ADDI r3,r1,-5 (0x0423FFFB) -> two cycles later ex_valid=1, ex_op=000001, ex_dest=3, ex_imm=0xFFFFFFFB, ex_use_imm=1, id_dest=3.
- Write r1=0x1234 via wb, then feed ADD r4,r1,r0 -> ex_rs_val=0x1234, ex_rt_val=0, ex_dest=4.
- Write r0=0xFFFF, then read r0 -> 0; STW or BEQ -> ex_reg_write=0, id_dest=0.
- Hold stall=1 for 2 cycles while a SUB is in IF/ID -> two bubbles (ex_valid=0), then SUB emerges once with the correct fields; flush+stall together -> the word is dropped.
- Feed HALT (0x44000000) followed by ADD -> halted=1 and stays 1; ADD never valid; opcode 111111 -> illegal_op pulses once.
- Write r2=7 with wb_en while decoding a word with rs=2 -> ex_rs_val=7 with RF_BYPASS_EN, old value without it.
